ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.
- Contains operand forwarding muxes, the ALU, branch-target adder and destination-register select.
- Contains an iterative 32-cycle unsigned multiply/divide unit with HI/LO registers. The unit stalls the front of the pipeline while busy.
- Results are registered into the EX/MEM pipeline register, which is part of this block.

---
 rtl/ex_pkg.sv | 57 +++++
 rtl/ex_stage_if.sv | 38 +++
 rtl/md_unit.sv | 104 ++++++++++
 rtl/ex_stage.sv | 107 ++++++++++
 tb/tb_ex_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared constants and types for the MIPS execute stage: ALU opcodes,
// forwarding selects, the multiply/divide FSM states and the EX/MEM record.
package ex_pkg;

  localparam int MD_CYCLES_DEF = 32;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_NOR   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_LUI   = 4'hB;
  localparam logic [3:0] ALU_MULTU = 4'hC;
  localparam logic [3:0] ALU_DIVU  = 4'hD;
  localparam logic [3:0] ALU_MFHI  = 4'hE;
  localparam logic [3:0] ALU_MFLO  = 4'hF;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        zero;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [31:0] pc_branch;
    logic [4:0]  write_reg;
  } exmem_t;

  // Code 2'b11 is unused by the hazard unit and falls back to the register file.
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] wb, input logic [31:0] mem);
    case (sel)
      FWD_RF:  return rf;
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, plus
// debug visibility of the multiply/divide FSM and HI/LO.
interface ex_stage_if;
  import ex_pkg::*;

  logic        RegWriteE, MemtoRegE, MemWriteE, BranchE;
  logic        ALUSrcE, RegDstE, ShamtConE, ZeroExtendE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, imme, PCPlus4E, ResultW;
  logic [4:0]  RtE, RdE, SaE;
  logic [1:0]  ForwardAE, ForwardBE;

  // StallE is the only flow control: while high the upstream stages hold their
  // instruction, and EX/MEM receives a bubble (control zero, data held).
  logic        StallE;
  logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
  logic [31:0] ALUOutM, WriteDataM, PCBranchM;
  logic [4:0]  WriteRegM;

  md_state_e   dbg_md_state;
  logic [31:0] dbg_hi, dbg_lo;

  modport slave (
    input  RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ShamtConE,
           ZeroExtendE, ALUControlE, RD1E, RD2E, imme, PCPlus4E, ResultW, RtE, RdE,
           SaE, ForwardAE, ForwardBE,
    output StallE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, ALUOutM,
           WriteDataM, PCBranchM, WriteRegM, dbg_md_state, dbg_hi, dbg_lo
  );

  modport master (
    output RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ShamtConE,
           ZeroExtendE, ALUControlE, RD1E, RD2E, imme, PCPlus4E, ResultW, RtE, RdE,
           SaE, ForwardAE, ForwardBE,
    input  StallE, RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, ALUOutM,
           WriteDataM, PCBranchM, WriteRegM, dbg_md_state, dbg_hi, dbg_lo
  );
endinterface

// File: rtl/md_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle, with the HI/LO architectural registers.
module md_unit
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done_pulse,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   state
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0] acc_q, acc_d, step;
  logic [31:0] op_q, op_d, hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d;
  logic [32:0] sum, shifted;
  logic [31:0] diff;
  logic        ge;

  // acc holds {partial product, multiplier} for MULTU, {remainder, quotient} for DIVU.
  always_comb begin
    sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_q} : 33'd0);
    shifted = acc_q[63:31];
    diff    = shifted[31:0] - op_q;
    ge      = (shifted >= {1'b0, op_q});
    if (div_q) begin
      step = ge ? {diff, acc_q[30:0], 1'b1} : {shifted[31:0], acc_q[30:0], 1'b0};
    end else begin
      step = {sum, acc_q[31:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    op_d    = op_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {32'd0, (is_div ? a : b)};
          op_d    = is_div ? b : a;
          div_d   = is_div;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = step;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          hi_d    = step[63:32];
          lo_d    = step[31:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign done_pulse = (state_q == DONE);
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign state      = state_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU, branch target, destination
// select, multiply/divide stall glue and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input logic       CLK,
  input logic       RESET,
  ex_stage_if.slave bus
);

  exmem_t      exmem_q, exmem_d;
  logic [31:0] src_a, fwd_b, src_b, imm_ext, alu_res;
  logic [31:0] md_hi, md_lo;
  logic [4:0]  shamt;
  logic        md_op, md_busy, md_done, stall;
  md_state_e   md_state;

  always_comb begin
    src_a   = fwd(bus.ForwardAE, bus.RD1E, bus.ResultW, exmem_q.alu_out);
    fwd_b   = fwd(bus.ForwardBE, bus.RD2E, bus.ResultW, exmem_q.alu_out);
    imm_ext = bus.ZeroExtendE ? {16'd0, bus.imme[15:0]} : bus.imme;
    src_b   = bus.ALUSrcE ? imm_ext : fwd_b;
    shamt   = bus.ShamtConE ? bus.SaE : src_a[4:0];
  end

  always_comb begin
    alu_res = 32'd0;
    case (bus.ALUControlE)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_res = (src_a < src_b) ? 32'd1 : 32'd0;
      ALU_SLL:  alu_res = src_b << shamt;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SRA:  alu_res = $signed(src_b) >>> shamt;
      ALU_LUI:  alu_res = {src_b[15:0], 16'd0};
      ALU_MFHI: alu_res = md_hi;
      ALU_MFLO: alu_res = md_lo;
      default:  alu_res = 32'd0;
    endcase
  end

  assign md_op = (bus.ALUControlE == ALU_MULTU) || (bus.ALUControlE == ALU_DIVU);

  md_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (md_op),
    .is_div     (bus.ALUControlE == ALU_DIVU),
    .a          (src_a),
    .b          (fwd_b),
    .busy       (md_busy),
    .done_pulse (md_done),
    .hi         (md_hi),
    .lo         (md_lo),
    .state      (md_state)
  );

  // In DONE the held MD instruction is still in EX but must be let through.
  assign stall = md_busy | (md_op & ~md_done);

  always_comb begin
    exmem_d = exmem_q;
    if (stall) begin
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_to_reg = 1'b0;
      exmem_d.mem_write  = 1'b0;
      exmem_d.branch     = 1'b0;
    end else begin
      exmem_d.reg_write  = bus.RegWriteE;
      exmem_d.mem_to_reg = bus.MemtoRegE;
      exmem_d.mem_write  = bus.MemWriteE;
      exmem_d.branch     = bus.BranchE;
      exmem_d.zero       = (alu_res == 32'd0);
      exmem_d.alu_out    = alu_res;
      exmem_d.write_data = fwd_b;
      exmem_d.pc_branch  = bus.PCPlus4E + {bus.imme[29:0], 2'b00};
      exmem_d.write_reg  = bus.RegDstE ? bus.RdE : bus.RtE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign bus.StallE       = stall;
  assign bus.RegWriteM    = exmem_q.reg_write;
  assign bus.MemtoRegM    = exmem_q.mem_to_reg;
  assign bus.MemWriteM    = exmem_q.mem_write;
  assign bus.BranchM      = exmem_q.branch;
  assign bus.ZeroM        = exmem_q.zero;
  assign bus.ALUOutM      = exmem_q.alu_out;
  assign bus.WriteDataM   = exmem_q.write_data;
  assign bus.PCBranchM    = exmem_q.pc_branch;
  assign bus.WriteRegM    = exmem_q.write_reg;
  assign bus.dbg_md_state = md_state;
  assign bus.dbg_hi       = md_hi;
  assign bus.dbg_lo       = md_lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand
// sequences for MULTU/DIVU stalls, HI/LO readback and reset during BUSY.
module tb_ex_stage;
  import ex_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  ex_stage_if bus();

  ex_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  alu;
    logic [1:0]  fa, fb;
    logic [3:0]  ctl;   // RegWrite, MemtoReg, MemWrite, Branch
    logic [3:0]  sel;   // ALUSrc, RegDst, ShamtCon, ZeroExtend
    logic [31:0] rd1, rd2, imme, pc4, resw;
    logic [4:0]  rt, rd, sa;
    logic [31:0] e_alu;
    logic        e_zero;
    logic [31:0] e_wd, e_pcb;
    logic [4:0]  e_wr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ctl_m();
    return {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.BranchM};
  endfunction

  task automatic set_nop();
    bus.ALUControlE = ALU_ADD;
    {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE} = 4'b0000;
    {bus.ALUSrcE, bus.RegDstE, bus.ShamtConE, bus.ZeroExtendE} = 4'b0000;
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_RF;
    bus.RD1E = 32'd0; bus.RD2E = 32'd0; bus.imme = 32'd0;
    bus.PCPlus4E = 32'd0; bus.ResultW = 32'd0;
    bus.RtE = 5'd0; bus.RdE = 5'd0; bus.SaE = 5'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.ALUControlE = v.alu;
    bus.ForwardAE = v.fa;
    bus.ForwardBE = v.fb;
    {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE} = v.ctl;
    {bus.ALUSrcE, bus.RegDstE, bus.ShamtConE, bus.ZeroExtendE} = v.sel;
    bus.RD1E = v.rd1; bus.RD2E = v.rd2; bus.imme = v.imme;
    bus.PCPlus4E = v.pc4; bus.ResultW = v.resw;
    bus.RtE = v.rt; bus.RdE = v.rd; bus.SaE = v.sa;
  endtask

  // Launch one MULTU/DIVU, count stall cycles, then read HI and LO back via MFHI/MFLO.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] ctl,
                        input logic [31:0] prev_alu, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    set_nop();
    bus.ALUControlE = op;
    bus.RD1E = a;
    bus.RD2E = b;
    {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE} = ctl;
    bus.RtE = 5'd3;
    #1;
    n = 0;
    while (bus.StallE && n < 100) begin
      @(posedge CLK); #1;
      n++;
      chk({tag, "_bubble_ctl"}, {28'd0, ctl_m()}, 32'd0);
    end
    chk({tag, "_stall_cycles"}, n, 32'd33);
    chk({tag, "_state_done"}, 32'(bus.dbg_md_state), 32'(DONE));
    chk({tag, "_alu_held"}, bus.ALUOutM, prev_alu);
    chk({tag, "_hi"}, bus.dbg_hi, exp_hi);
    chk({tag, "_lo"}, bus.dbg_lo, exp_lo);
    @(posedge CLK); #1;
    chk({tag, "_advance_ctl"}, {28'd0, ctl_m()}, {28'd0, ctl});
    set_nop();
    bus.ALUControlE = ALU_MFHI;
    #1;
    chk({tag, "_no_relaunch"}, {31'd0, bus.StallE}, 32'd0);
    chk({tag, "_state_idle"}, 32'(bus.dbg_md_state), 32'(IDLE));
    @(posedge CLK); #1;
    chk({tag, "_mfhi"}, bus.ALUOutM, exp_hi);
    bus.ALUControlE = ALU_MFLO;
    @(posedge CLK); #1;
    chk({tag, "_mflo"}, bus.ALUOutM, exp_lo);
  endtask

  initial begin
    //            alu       fa  fb  ctl      sel      rd1           rd2           imme          pc4           resw          rt     rd     sa      e_alu         z     e_wd          e_pcb         e_wr
    tbl[0]  = '{ALU_SUB,  2'd1, 2'd0, 4'b1000, 4'b0000, 32'h00000099, 32'h00000003, 32'h00000000, 32'h00001000, 32'h00000005, 5'd2,  5'd3,  5'd0,  32'h00000002, 1'b0, 32'h00000003, 32'h00001000, 5'd2};
    tbl[1]  = '{ALU_ADD,  2'd2, 2'd1, 4'b1100, 4'b0000, 32'h0000dead, 32'h0000beef, 32'h00000004, 32'h00001000, 32'h00000010, 5'd4,  5'd5,  5'd0,  32'h00000012, 1'b0, 32'h00000010, 32'h00001010, 5'd4};
    tbl[2]  = '{ALU_SRA,  2'd0, 2'd0, 4'b1000, 4'b0010, 32'h0000001f, 32'h80000000, 32'h00000000, 32'h00002000, 32'h00000000, 5'd6,  5'd7,  5'd4,  32'hf8000000, 1'b0, 32'h80000000, 32'h00002000, 5'd6};
    tbl[3]  = '{ALU_SLL,  2'd0, 2'd0, 4'b0010, 4'b0010, 32'h0000001f, 32'h80000000, 32'h00000000, 32'h00002000, 32'h00000000, 5'd6,  5'd7,  5'd4,  32'h00000000, 1'b1, 32'h80000000, 32'h00002000, 5'd6};
    tbl[4]  = '{ALU_SUB,  2'd0, 2'd0, 4'b0001, 4'b0000, 32'h00000007, 32'h00000007, 32'hfffffffe, 32'h00000100, 32'h00000000, 5'd8,  5'd0,  5'd0,  32'h00000000, 1'b1, 32'h00000007, 32'h000000f8, 5'd8};
    tbl[5]  = '{ALU_OR,   2'd0, 2'd0, 4'b1000, 4'b1101, 32'h12340000, 32'h00000055, 32'hffff8001, 32'h00001000, 32'h00000000, 5'd1,  5'd9,  5'd0,  32'h12348001, 1'b0, 32'h00000055, 32'hfffe1004, 5'd9};
    tbl[6]  = '{ALU_ADD,  2'd0, 2'd0, 4'b1000, 4'b1000, 32'h00000000, 32'h00000066, 32'hffffffff, 32'h00001000, 32'h00000000, 5'd10, 5'd0,  5'd0,  32'hffffffff, 1'b0, 32'h00000066, 32'h00000ffc, 5'd10};
    tbl[7]  = '{ALU_SLT,  2'd3, 2'd3, 4'b1000, 4'b0000, 32'hffffffff, 32'h00000001, 32'h00000000, 32'h00000040, 32'h0000aaaa, 5'd11, 5'd0,  5'd0,  32'h00000001, 1'b0, 32'h00000001, 32'h00000040, 5'd11};
    tbl[8]  = '{ALU_SLTU, 2'd0, 2'd0, 4'b1000, 4'b0000, 32'hffffffff, 32'h00000001, 32'h00000000, 32'h00000040, 32'h00000000, 5'd11, 5'd0,  5'd0,  32'h00000000, 1'b1, 32'h00000001, 32'h00000040, 5'd11};
    tbl[9]  = '{ALU_NOR,  2'd0, 2'd0, 4'b1000, 4'b0000, 32'h00000000, 32'h0f0f0f0f, 32'h00000000, 32'h00000040, 32'h00000000, 5'd12, 5'd0,  5'd0,  32'hf0f0f0f0, 1'b0, 32'h0f0f0f0f, 32'h00000040, 5'd12};
    tbl[10] = '{ALU_XOR,  2'd0, 2'd0, 4'b1000, 4'b0000, 32'hff00ff00, 32'h0f0f0f0f, 32'h00000000, 32'h00000040, 32'h00000000, 5'd13, 5'd0,  5'd0,  32'hf00ff00f, 1'b0, 32'h0f0f0f0f, 32'h00000040, 5'd13};
    tbl[11] = '{ALU_SRL,  2'd0, 2'd0, 4'b1000, 4'b0000, 32'h00000008, 32'h80000000, 32'h00000000, 32'h00000040, 32'h00000000, 5'd14, 5'd0,  5'd31, 32'h00800000, 1'b0, 32'h80000000, 32'h00000040, 5'd14};
    tbl[12] = '{ALU_LUI,  2'd0, 2'd0, 4'b1000, 4'b1001, 32'h00000000, 32'h00000077, 32'h00001234, 32'h00000040, 32'h00000000, 5'd15, 5'd0,  5'd0,  32'h12340000, 1'b0, 32'h00000077, 32'h00004910, 5'd15};
    tbl[13] = '{ALU_AND,  2'd0, 2'd2, 4'b0110, 4'b0000, 32'hffff0000, 32'h00000000, 32'h00000000, 32'h00000040, 32'h00000000, 5'd16, 5'd0,  5'd0,  32'h12340000, 1'b0, 32'h12340000, 32'h00000040, 5'd16};
    tbl[14] = '{ALU_ADD,  2'd0, 2'd0, 4'b1000, 4'b0100, 32'hffffffff, 32'h00000001, 32'h00000000, 32'h00000040, 32'h00000000, 5'd17, 5'd18, 5'd0,  32'h00000000, 1'b1, 32'h00000001, 32'h00000040, 5'd18};
    tbl[15] = '{ALU_OR,   2'd0, 2'd0, 4'b1000, 4'b0000, 32'h0000a5a5, 32'h00000000, 32'h00000000, 32'h00000040, 32'h00000000, 5'd19, 5'd0,  5'd0,  32'h0000a5a5, 1'b0, 32'h00000000, 32'h00000040, 5'd19};

    set_nop();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_alu", bus.ALUOutM, 32'd0);
    chk("rst_ctl", {28'd0, ctl_m()}, 32'd0);
    chk("rst_zero", {31'd0, bus.ZeroM}, 32'd0);
    chk("rst_wd", bus.WriteDataM, 32'd0);
    chk("rst_pcb", bus.PCBranchM, 32'd0);
    chk("rst_wr", {27'd0, bus.WriteRegM}, 32'd0);
    chk("rst_stall", {31'd0, bus.StallE}, 32'd0);
    chk("rst_state", 32'(bus.dbg_md_state), 32'(IDLE));
    chk("rst_hilo", bus.dbg_hi | bus.dbg_lo, 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive_vec(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.StallE}, 32'd0);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_alu", i), bus.ALUOutM, tbl[i].e_alu);
      chk($sformatf("v%0d_zero", i), {31'd0, bus.ZeroM}, {31'd0, tbl[i].e_zero});
      chk($sformatf("v%0d_wd", i), bus.WriteDataM, tbl[i].e_wd);
      chk($sformatf("v%0d_pcb", i), bus.PCBranchM, tbl[i].e_pcb);
      chk($sformatf("v%0d_wr", i), {27'd0, bus.WriteRegM}, {27'd0, tbl[i].e_wr});
      chk($sformatf("v%0d_ctl", i), {28'd0, ctl_m()}, {28'd0, tbl[i].ctl});
    end

    run_md("mul", ALU_MULTU, 32'hffffffff, 32'h00000002, 4'b1111, 32'h0000a5a5,
           32'h00000001, 32'hfffffffe);
    run_md("div", ALU_DIVU, 32'd100, 32'd7, 4'b0000, 32'hfffffffe, 32'd2, 32'd14);
    run_md("div0", ALU_DIVU, 32'h00001234, 32'd0, 4'b0100, 32'd14,
           32'h00001234, 32'hffffffff);

    // Reset arriving mid-BUSY (count 10) must discard the partial result.
    set_nop();
    bus.ALUControlE = ALU_MULTU;
    bus.RD1E = 32'd5;
    bus.RD2E = 32'd6;
    repeat (11) @(posedge CLK);
    #1;
    chk("rst_busy_pre_state", 32'(bus.dbg_md_state), 32'(BUSY));
    RESET = 1'b1;
    set_nop();
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    chk("rst_busy_stall", {31'd0, bus.StallE}, 32'd0);
    chk("rst_busy_state", 32'(bus.dbg_md_state), 32'(IDLE));
    chk("rst_busy_hi", bus.dbg_hi, 32'd0);
    chk("rst_busy_lo", bus.dbg_lo, 32'd0);
    chk("rst_busy_alu", bus.ALUOutM, 32'd0);
    chk("rst_busy_pcb", bus.PCBranchM, 32'd0);
    chk("rst_busy_ctl", {28'd0, ctl_m()}, 32'd0);

    run_md("mul2", ALU_MULTU, 32'h00010001, 32'h00010001, 4'b0000, 32'd0,
           32'h00000001, 32'h00020001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
